// File: rtl/voice_allocator_if.sv
// Note-event handshake between the MIDI front end (master) and the voice allocator (slave).
interface voice_allocator_if #(
    parameter int NOTE_BITS = 7,
    parameter int FREQ_BITS = 16
);
    logic                 note_valid;
    logic                 note_ready;
    logic                 note_on;
    logic [NOTE_BITS-1:0] note_num;
    logic [FREQ_BITS-1:0] note_freq;

    modport master (output note_valid, note_on, note_num, note_freq, input note_ready);
    modport slave  (input note_valid, note_on, note_num, note_freq, output note_ready);
endinterface

// File: rtl/voice_allocator.sv
// Polyphonic note-to-voice allocator: tiered priority search, oldest-voice stealing with retrigger gap.
// Define SUSTAIN_PEDAL_EN to add the sustain input and per-voice held flags.
module voice_allocator #(
    parameter int NUM_VOICES       = 4,
    parameter int FREQ_BITS        = 16,
    parameter int NOTE_BITS        = 7,
    parameter int RETRIGGER_CYCLES = 1024
) (
    input  logic                            main_clk,
    input  logic                            rst_n,
    voice_allocator_if.slave                ev,
`ifdef SUSTAIN_PEDAL_EN
    input  logic                            sustain,
`endif
    input  logic [NUM_VOICES-1:0]           voice_idle,
    output logic [NUM_VOICES-1:0]           gate,
    output logic [NUM_VOICES*FREQ_BITS-1:0] tone_freq,
    output logic                            steal
);
    localparam int VW = $clog2(NUM_VOICES);
    localparam int CW = $clog2(RETRIGGER_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_APPLY, S_HOLD} state_t;
    typedef logic [1:0] tier_t;
    localparam tier_t T_HELD  = 2'd0;
    localparam tier_t T_FREE  = 2'd1;
    localparam tier_t T_REL   = 2'd2;
    localparam tier_t T_STEAL = 2'd3;

    state_t                          state_q, state_d;
    logic                            ready_q, ready_d;
    logic [NUM_VOICES-1:0]           gate_q, gate_d;
    logic [NUM_VOICES*FREQ_BITS-1:0] freq_q, freq_d;
    logic                            steal_q, steal_d;
    logic [VW-1:0]                   rank_q [NUM_VOICES];
    logic [VW-1:0]                   rank_d [NUM_VOICES];
    logic [NOTE_BITS-1:0]            note_q [NUM_VOICES];
    logic [NOTE_BITS-1:0]            note_d [NUM_VOICES];
    logic                            ev_on_q, ev_on_d;
    logic [NOTE_BITS-1:0]            ev_num_q, ev_num_d;
    logic [FREQ_BITS-1:0]            ev_freq_q, ev_freq_d;
    logic [VW-1:0]                   scan_k_q, scan_k_d;
    logic                            best_valid_q, best_valid_d;
    logic [VW-1:0]                   best_idx_q, best_idx_d;
    tier_t                           best_tier_q, best_tier_d;
    logic [CW-1:0]                   hold_cnt_q, hold_cnt_d;
`ifdef SUSTAIN_PEDAL_EN
    logic [NUM_VOICES-1:0]           held_q, held_d;
    logic                            sustain_q, sustain_d;
    logic                            sus_seen_q, sus_seen_d;
`endif

    logic                            cand_ok_s;
    tier_t                           cand_tier_s;
    logic                            better_s;
    logic                            do_retune_s;
    logic [VW-1:0]                   promo_rank_s [NUM_VOICES];

    assign ev.note_ready = ready_q;
    assign gate          = gate_q;
    assign tone_freq     = freq_q;
    assign steal         = steal_q;

    // Classify the voice under scan and decide whether it beats the best candidate so far.
    always_comb begin
        cand_ok_s   = 1'b0;
        cand_tier_s = T_STEAL;
        if (ev_on_q) begin
            cand_ok_s = 1'b1;
            if (gate_q[scan_k_q] && (note_q[scan_k_q] == ev_num_q)) begin
                cand_tier_s = T_HELD;
            end else if (gate_q[scan_k_q]) begin
                cand_tier_s = T_STEAL;
            end else if (voice_idle[scan_k_q]) begin
                cand_tier_s = T_FREE;
            end else begin
                cand_tier_s = T_REL;
            end
        end else begin
            cand_ok_s   = gate_q[scan_k_q] && (note_q[scan_k_q] == ev_num_q);
            cand_tier_s = T_HELD;
        end
        better_s = cand_ok_s && (!best_valid_q || (cand_tier_s < best_tier_q) ||
                   ((cand_tier_s == best_tier_q) && (rank_q[scan_k_q] > rank_q[best_idx_q])));
    end

    // Ages after making the chosen voice the youngest; keeps the ranks a permutation.
    always_comb begin
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (VW'(i) == best_idx_q) begin
                promo_rank_s[i] = {VW{1'b0}};
            end else if (rank_q[i] < rank_q[best_idx_q]) begin
                promo_rank_s[i] = rank_q[i] + 1'b1;
            end else begin
                promo_rank_s[i] = rank_q[i];
            end
        end
    end

    // Next-state and output logic for the IDLE/SCAN/APPLY/HOLD sequencer.
    always_comb begin
        state_d      = state_q;
        gate_d       = gate_q;
        freq_d       = freq_q;
        steal_d      = 1'b0;
        rank_d       = rank_q;
        note_d       = note_q;
        ev_on_d      = ev_on_q;
        ev_num_d     = ev_num_q;
        ev_freq_d    = ev_freq_q;
        scan_k_d     = scan_k_q;
        best_valid_d = best_valid_q;
        best_idx_d   = best_idx_q;
        best_tier_d  = best_tier_q;
        hold_cnt_d   = hold_cnt_q;
        do_retune_s  = 1'b0;
`ifdef SUSTAIN_PEDAL_EN
        held_d       = held_q;
        sustain_d    = sustain;
        sus_seen_d   = (state_q == S_IDLE) ? sustain_q : sus_seen_q;
`endif
        case (state_q)
            S_IDLE: begin
`ifdef SUSTAIN_PEDAL_EN
                // Pedal release: every voice kept alive by the pedal drops its gate together.
                if (sus_seen_q && !sustain_q) begin
                    gate_d = gate_q & ~held_q;
                    held_d = {NUM_VOICES{1'b0}};
                end else begin
                    held_d = held_q;
                end
`endif
                if (ready_q && ev.note_valid) begin
                    ev_on_d      = ev.note_on;
                    ev_num_d     = ev.note_num;
                    ev_freq_d    = ev.note_freq;
                    scan_k_d     = {VW{1'b0}};
                    best_valid_d = 1'b0;
                    state_d      = S_SCAN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SCAN: begin
                if (better_s) begin
                    best_valid_d = 1'b1;
                    best_idx_d   = scan_k_q;
                    best_tier_d  = cand_tier_s;
                end else begin
                    best_valid_d = best_valid_q;
                end
                if (scan_k_q == VW'(NUM_VOICES - 1)) begin
                    state_d = S_APPLY;
                end else begin
                    scan_k_d = scan_k_q + 1'b1;
                end
            end
            S_APPLY: begin
                state_d = S_IDLE;
                if (!best_valid_q) begin
                    state_d = S_IDLE;
                end else if (!ev_on_q) begin
`ifdef SUSTAIN_PEDAL_EN
                    if (sustain_q) begin
                        held_d[best_idx_q] = 1'b1;
                    end else begin
                        gate_d[best_idx_q] = 1'b0;
                    end
`else
                    gate_d[best_idx_q] = 1'b0;
`endif
                end else begin
                    case (best_tier_q)
                        T_HELD: begin
                            do_retune_s = 1'b1;
                            rank_d      = promo_rank_s;
`ifdef SUSTAIN_PEDAL_EN
                            held_d[best_idx_q] = 1'b0;
`endif
                        end
                        T_FREE, T_REL: begin
                            do_retune_s        = 1'b1;
                            gate_d[best_idx_q] = 1'b1;
                            note_d[best_idx_q] = ev_num_q;
                            rank_d             = promo_rank_s;
                        end
                        T_STEAL: begin
                            // Drop the gate long enough for the voice to see a fresh attack.
                            gate_d[best_idx_q] = 1'b0;
                            note_d[best_idx_q] = ev_num_q;
                            steal_d            = 1'b1;
                            hold_cnt_d         = {CW{1'b0}};
                            state_d            = S_HOLD;
`ifdef SUSTAIN_PEDAL_EN
                            held_d[best_idx_q] = 1'b0;
`endif
                        end
                        default: state_d = S_IDLE;
                    endcase
                end
            end
            S_HOLD: begin
                if (hold_cnt_q == CW'(RETRIGGER_CYCLES - 1)) begin
                    do_retune_s        = 1'b1;
                    gate_d[best_idx_q] = 1'b1;
                    rank_d             = promo_rank_s;
                    state_d            = S_IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        for (int i = 0; i < NUM_VOICES; i++) begin
            if (do_retune_s && (VW'(i) == best_idx_q)) begin
                freq_d[i*FREQ_BITS +: FREQ_BITS] = ev_freq_q;
            end else begin
                freq_d[i*FREQ_BITS +: FREQ_BITS] = freq_d[i*FREQ_BITS +: FREQ_BITS];
            end
        end

        ready_d = (state_d == S_IDLE);
`ifdef SUSTAIN_PEDAL_EN
        // Hold off the handshake for the cycle in which the pedal release is processed.
        if (sus_seen_d && !sustain) begin
            ready_d = 1'b0;
        end else begin
            ready_d = (state_d == S_IDLE);
        end
`endif
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge main_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            ready_q      <= 1'b0;
            gate_q       <= {NUM_VOICES{1'b0}};
            freq_q       <= {(NUM_VOICES*FREQ_BITS){1'b0}};
            steal_q      <= 1'b0;
            ev_on_q      <= 1'b0;
            ev_num_q     <= {NOTE_BITS{1'b0}};
            ev_freq_q    <= {FREQ_BITS{1'b0}};
            scan_k_q     <= {VW{1'b0}};
            best_valid_q <= 1'b0;
            best_idx_q   <= {VW{1'b0}};
            best_tier_q  <= T_HELD;
            hold_cnt_q   <= {CW{1'b0}};
            for (int i = 0; i < NUM_VOICES; i++) begin
                rank_q[i] <= VW'(i);
                note_q[i] <= {NOTE_BITS{1'b0}};
            end
`ifdef SUSTAIN_PEDAL_EN
            held_q       <= {NUM_VOICES{1'b0}};
            sustain_q    <= 1'b0;
            sus_seen_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            ready_q      <= ready_d;
            gate_q       <= gate_d;
            freq_q       <= freq_d;
            steal_q      <= steal_d;
            ev_on_q      <= ev_on_d;
            ev_num_q     <= ev_num_d;
            ev_freq_q    <= ev_freq_d;
            scan_k_q     <= scan_k_d;
            best_valid_q <= best_valid_d;
            best_idx_q   <= best_idx_d;
            best_tier_q  <= best_tier_d;
            hold_cnt_q   <= hold_cnt_d;
            rank_q       <= rank_d;
            note_q       <= note_d;
`ifdef SUSTAIN_PEDAL_EN
            held_q       <= held_d;
            sustain_q    <= sustain_d;
            sus_seen_q   <= sus_seen_d;
`endif
        end
    end
endmodule

// File: tb/tb_voice_allocator.sv
// Scoreboard bench for voice_allocator: stimulus queues expected output changes, a monitor thread checks them.
module tb_voice_allocator;
    localparam int NV = 4;
    localparam int FB = 16;
    localparam int NB = 7;
    localparam int RC = 8;

    typedef struct packed {
        logic [31:0]       cyc;
        logic [NV-1:0]     g;
        logic [NV*FB-1:0]  f;
        logic              s;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NV-1:0]     voice_idle;
    logic [NV-1:0]     gate;
    logic [NV*FB-1:0]  tone_freq;
    logic              steal;
`ifdef SUSTAIN_PEDAL_EN
    logic              sustain;
`endif

    int                checks = 0;
    int                failures = 0;
    int                cyc = 0;
    exp_t              sb_q[$];
    exp_t              mon_e;
    logic [NV-1:0]     exp_g;
    logic [NV*FB-1:0]  exp_f;
    logic [NV+NV*FB:0] prev_s;
    bit                mon_en = 1'b0;
    int                acc;

    voice_allocator_if #(.NOTE_BITS(NB), .FREQ_BITS(FB)) ev ();

    voice_allocator #(
        .NUM_VOICES(NV), .FREQ_BITS(FB), .NOTE_BITS(NB), .RETRIGGER_CYCLES(RC)
    ) dut (
        .main_clk   (clk),
        .rst_n      (rst_n),
        .ev         (ev),
`ifdef SUSTAIN_PEDAL_EN
        .sustain    (sustain),
`endif
        .voice_idle (voice_idle),
        .gate       (gate),
        .tone_freq  (tone_freq),
        .steal      (steal)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, expv);
        end
    endtask

    task automatic setf(input int v, input logic [FB-1:0] val);
        exp_f[v*FB +: FB] = val;
    endtask

    task automatic push(input int c, input logic s);
        exp_t e;
        e.cyc = c;
        e.g = exp_g;
        e.f = exp_f;
        e.s = s;
        sb_q.push_back(e);
    endtask

    task automatic send(input logic on, input logic [NB-1:0] num, input logic [FB-1:0] fr, output int a);
        int n;
        @(negedge clk);
        ev.note_valid = 1'b1;
        ev.note_on    = on;
        ev.note_num   = num;
        ev.note_freq  = fr;
        n = 0;
        while (ev.note_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 200) begin
            failures++;
            $display("FAIL send_timeout note=%0d actual_ready=%b required_ready=1", num, ev.note_ready);
        end
        a = cyc + 1;
        @(negedge clk);
        ev.note_valid = 1'b0;
    endtask

    task automatic wait_done();
        int  n;
        bit  ok;
        n  = 0;
        ok = 1'b0;
        while (!ok && n < 100) begin
            @(negedge clk);
            #1;
            ok = (ev.note_ready === 1'b1) && (sb_q.size() == 0);
            n++;
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL drain_timeout actual_pending=%0d required_pending=0 ready=%b", sb_q.size(), ev.note_ready);
        end
        chk("gate_state", 64'(gate), 64'(exp_g));
        chk("freq_state", 64'(tone_freq), 64'(exp_f));
    endtask

    initial begin
        rst_n         = 1'b0;
        ev.note_valid = 1'b0;
        ev.note_on    = 1'b0;
        ev.note_num   = 7'd0;
        ev.note_freq  = 16'h0000;
        voice_idle    = 4'b1111;
`ifdef SUSTAIN_PEDAL_EN
        sustain       = 1'b0;
`endif
        exp_g  = 4'b0000;
        exp_f  = 64'h0;
        prev_s = '0;
        fork
            begin : monitor
                forever begin
                    @(negedge clk);
                    if (mon_en && ({gate, tone_freq, steal} != prev_s)) begin
                        checks++;
                        if (sb_q.size() == 0) begin
                            failures++;
                            $display("FAIL unexpected_change cyc=%0d gate=%b freq=%h steal=%b required=no_change",
                                     cyc, gate, tone_freq, steal);
                        end else begin
                            mon_e = sb_q.pop_front();
                            if (mon_e.cyc != 32'(cyc) || mon_e.g !== gate || mon_e.f !== tone_freq || mon_e.s !== steal) begin
                                failures++;
                                $display("FAIL out_event actual cyc=%0d gate=%b freq=%h steal=%b required cyc=%0d gate=%b freq=%h steal=%b",
                                         cyc, gate, tone_freq, steal, mon_e.cyc, mon_e.g, mon_e.f, mon_e.s);
                            end
                        end
                    end
                    if (mon_en) prev_s = {gate, tone_freq, steal};
                end
            end
            begin : stim
                // Reset values
                repeat (3) @(negedge clk);
                chk("rst_gate", 64'(gate), 64'h0);
                chk("rst_freq", 64'(tone_freq), 64'h0);
                chk("rst_steal", 64'(steal), 64'h0);
                chk("rst_ready", 64'(ev.note_ready), 64'h0);
                rst_n = 1'b1;
                @(negedge clk);
                chk("ready_after_rst", 64'(ev.note_ready), 64'h1);
                prev_s = {gate, tone_freq, steal};
                mon_en = 1'b1;

                // Fill four free voices, oldest first
                send(1'b1, 7'd60, 16'h1000, acc); exp_g = 4'b1000; setf(3, 16'h1000); push(acc + 5, 1'b0); wait_done();
                send(1'b1, 7'd62, 16'h2000, acc); exp_g = 4'b1100; setf(2, 16'h2000); push(acc + 5, 1'b0); wait_done();
                send(1'b1, 7'd64, 16'h3000, acc); exp_g = 4'b1110; setf(1, 16'h3000); push(acc + 5, 1'b0); wait_done();
                send(1'b1, 7'd65, 16'h4000, acc); exp_g = 4'b1111; setf(0, 16'h4000); push(acc + 5, 1'b0); wait_done();
                send(1'b0, 7'd62, 16'h0000, acc); exp_g = 4'b1011; push(acc + 5, 1'b0); wait_done();

                // Releasing voice is reused when nothing is idle
                voice_idle = 4'b1011;
                send(1'b1, 7'd67, 16'h5000, acc); exp_g = 4'b1111; setf(2, 16'h5000); push(acc + 5, 1'b0); wait_done();
                voice_idle = 4'b1111;

                // Steal oldest (voice 3) with retrigger gap
                send(1'b1, 7'd70, 16'h6000, acc);
                exp_g = 4'b0111; push(acc + 5, 1'b1);
                push(acc + 6, 1'b0);
                exp_g = 4'b1111; setf(3, 16'h6000); push(acc + 5 + RC, 1'b0);
                wait_done();

                // Held note beats a free voice; legato retune
                send(1'b0, 7'd65, 16'h0000, acc); exp_g = 4'b1110; push(acc + 5, 1'b0); wait_done();
                send(1'b1, 7'd64, 16'h1100, acc); setf(1, 16'h1100); push(acc + 5, 1'b0); wait_done();
                send(1'b1, 7'd64, 16'h1180, acc); setf(1, 16'h1180); push(acc + 5, 1'b0); wait_done();
                send(1'b0, 7'd99, 16'h0000, acc); repeat (4) @(negedge clk); wait_done();
                send(1'b0, 7'd64, 16'h0000, acc); exp_g = 4'b1100; push(acc + 5, 1'b0); wait_done();
                send(1'b1, 7'd72, 16'h7000, acc); exp_g = 4'b1101; setf(0, 16'h7000); push(acc + 5, 1'b0); wait_done();
                send(1'b1, 7'd74, 16'h7400, acc); exp_g = 4'b1111; setf(1, 16'h7400); push(acc + 5, 1'b0); wait_done();

                // Steal voice 2, then reset in the middle of HOLD
                send(1'b1, 7'd76, 16'h7600, acc);
                exp_g = 4'b1011; push(acc + 5, 1'b1);
                push(acc + 6, 1'b0);
                while (cyc < acc + 9) @(negedge clk);
                chk("hold_pending", 64'(sb_q.size()), 64'h0);
                mon_en = 1'b0;
                #2 rst_n = 1'b0;
                #1;
                chk("midhold_gate", 64'(gate), 64'h0);
                chk("midhold_freq", 64'(tone_freq), 64'h0);
                chk("midhold_ready", 64'(ev.note_ready), 64'h0);
                @(negedge clk);
                rst_n = 1'b1;
                @(negedge clk);
                chk("ready_after_rst2", 64'(ev.note_ready), 64'h1);
                exp_g  = 4'b0000;
                exp_f  = 64'h0;
                prev_s = {gate, tone_freq, steal};
                mon_en = 1'b1;

                // Ranks restored by reset; duplicate note-on stays on one voice
                send(1'b1, 7'd60, 16'h1000, acc); exp_g = 4'b1000; setf(3, 16'h1000); push(acc + 5, 1'b0); wait_done();
                send(1'b1, 7'd60, 16'h1100, acc); setf(3, 16'h1100); push(acc + 5, 1'b0); wait_done();
                send(1'b0, 7'd99, 16'h0000, acc); repeat (4) @(negedge clk); wait_done();

`ifdef SUSTAIN_PEDAL_EN
                @(negedge clk);
                sustain = 1'b1;
                repeat (3) @(negedge clk);
                send(1'b1, 7'd80, 16'h8000, acc); exp_g = 4'b1100; setf(2, 16'h8000); push(acc + 5, 1'b0); wait_done();
                send(1'b0, 7'd80, 16'h0000, acc); repeat (4) @(negedge clk); wait_done();
                @(negedge clk);
                sustain = 1'b0;
                exp_g = 4'b1000; push(cyc + 2, 1'b0);
                wait_done();
`endif
                repeat (20) @(negedge clk);
                chk("final_pending", 64'(sb_q.size()), 64'h0);
            end
        join_any
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
